// File: rtl/instr_pkg.sv
// Shared opcode definitions for the instruction encoder/decoder pair.
// Holds the fixed one-hot-request to 4-bit opcode map and its helpers.
package instr_pkg;

    localparam int OP_W   = 4;
    localparam int CTRL_W = 11;

    localparam logic [OP_W-1:0] OP_S0  = 4'b0000;
    localparam logic [OP_W-1:0] OP_S1  = 4'b0001;
    localparam logic [OP_W-1:0] OP_S2  = 4'b0010;
    localparam logic [OP_W-1:0] OP_S3  = 4'b0011;
    localparam logic [OP_W-1:0] OP_S4  = 4'b0100;
    localparam logic [OP_W-1:0] OP_S5  = 4'b0110;
    localparam logic [OP_W-1:0] OP_S6  = 4'b0111;
    localparam logic [OP_W-1:0] OP_S7  = 4'b1000;
    localparam logic [OP_W-1:0] OP_S8  = 4'b1100;
    localparam logic [OP_W-1:0] OP_S9  = 4'b1001;
    localparam logic [OP_W-1:0] OP_S10 = 4'b1111;

    // Highest set request bit wins; an all-zero request maps to OP_S0.
    function automatic logic [OP_W-1:0] encode(input logic [CTRL_W-1:0] r);
        logic [OP_W-1:0] op;
        op = OP_S0;
        if      (r[10]) op = OP_S10;
        else if (r[9])  op = OP_S9;
        else if (r[8])  op = OP_S8;
        else if (r[7])  op = OP_S7;
        else if (r[6])  op = OP_S6;
        else if (r[5])  op = OP_S5;
        else if (r[4])  op = OP_S4;
        else if (r[3])  op = OP_S3;
        else if (r[2])  op = OP_S2;
        else if (r[1])  op = OP_S1;
        return op;
    endfunction

    function automatic logic is_onehot(input logic [CTRL_W-1:0] r);
        return ($countones(r) == 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage, explicit occupancy count
// and valid/ready-style qualification of writes (when full) and reads (when empty).
module sync_fifo #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Entries are cleared on reset so the head output is never X.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (do_wr && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/instruction_encoder.sv
// Encodes an 11-bit one-hot control request into a 4-bit opcode and buffers it in a FIFO.
// Optional macro ILLEGAL_CHECK_EN: drop non-one-hot requests and raise a sticky illegal flag.
module instruction_encoder
    import instr_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] req,
    input  logic              req_valid,
    output logic              req_ready,
    output logic [OP_W-1:0]   op,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [PTR_W:0]    count,
    output logic              illegal
);

    logic [OP_W-1:0] enc;
    logic            handshake;
    logic            push;
    logic            full;
    logic            empty;

    assign enc       = encode(req);
    assign handshake = req_valid && req_ready;

`ifdef ILLEGAL_CHECK_EN
    logic illegal_reg;

    // Bad requests are still consumed so the producer never stalls on them.
    assign push = handshake && is_onehot(req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_reg <= 1'b0;
        end else if (handshake && !is_onehot(req)) begin
            illegal_reg <= 1'b1;
        end
    end

    assign illegal = illegal_reg;
`else
    assign push    = handshake;
    assign illegal = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (OP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (enc),
        .rd_en   (op_ready),
        .rd_data (op),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign req_ready = !full;
    assign op_valid  = !empty;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed self-checking bench for instruction_encoder (DEPTH = 4).
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] req;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  op;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  count;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] exp_tab [0:10];

    instruction_encoder #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .count     (count),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        exp_tab[0]  = 4'b0000; exp_tab[1]  = 4'b0001; exp_tab[2]  = 4'b0010;
        exp_tab[3]  = 4'b0011; exp_tab[4]  = 4'b0100; exp_tab[5]  = 4'b0110;
        exp_tab[6]  = 4'b0111; exp_tab[7]  = 4'b1000; exp_tab[8]  = 4'b1100;
        exp_tab[9]  = 4'b1001; exp_tab[10] = 4'b1111;

        rst = 1'b1; req = '0; req_valid = 1'b0; op_ready = 1'b0;
        step(); step();
        check("rst_op_valid",  32'(op_valid),  32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_count",     32'(count),     32'd0);
        check("rst_op",        32'(op),        32'd0);
        check("rst_illegal",   32'(illegal),   32'd0);
        rst = 1'b0;

        // Encode map: push s0..s10 back to back while draining.
        op_ready = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            req = 11'(1 << i); req_valid = 1'b1;
            step();
            check($sformatf("map_op_s%0d", i), 32'(op), 32'(exp_tab[i]));
            check($sformatf("map_vld_s%0d", i), 32'(op_valid), 32'd1);
        end
        req_valid = 1'b0;
        step();
        check("map_drain_count", 32'(count), 32'd0);
        check("map_drain_vld",   32'(op_valid), 32'd0);

        // Fill with op_ready low: s1..s4 accepted, s5 held.
        op_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            req = 11'(1 << i); req_valid = 1'b1;
            check($sformatf("fill_ready_%0d", i), 32'(req_ready), 32'd1);
            step();
        end
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(req_ready), 32'd0);
        req = 11'(1 << 5);
        step();
        check("held_count", 32'(count), 32'd4);
        check("held_op",    32'(op),    32'b0001);
        // Full with pop and valid request: pop only.
        op_ready = 1'b1;
        step();
        check("fullpop_count", 32'(count), 32'd3);
        check("fullpop_ready", 32'(req_ready), 32'd1);
        check("fullpop_op",    32'(op), 32'b0010);
        step();
        check("s5_in_count", 32'(count), 32'd3);
        check("s5_in_op",    32'(op), 32'b0011);
        req_valid = 1'b0;
        step();
        check("drain1_op", 32'(op), 32'b0100);
        step();
        check("drain2_op", 32'(op), 32'b0110);
        check("drain2_count", 32'(count), 32'd1);
        step();
        check("drain3_vld", 32'(op_valid), 32'd0);

        // Steady state at count 2 with simultaneous push/pop across wrap.
        op_ready = 1'b0;
        req = 11'(1 << 6); req_valid = 1'b1; step();
        req = 11'(1 << 7); step();
        check("ss_count0", 32'(count), 32'd2);
        check("ss_op0",    32'(op), 32'b0111);
        op_ready = 1'b1;
        req = 11'(1 << 8);  step(); check("ss_op1", 32'(op), 32'b1000); check("ss_cnt1", 32'(count), 32'd2);
        req = 11'(1 << 9);  step(); check("ss_op2", 32'(op), 32'b1100); check("ss_cnt2", 32'(count), 32'd2);
        req = 11'(1 << 10); step(); check("ss_op3", 32'(op), 32'b1001); check("ss_cnt3", 32'(count), 32'd2);
        req = 11'(1 << 0);  step(); check("ss_op4", 32'(op), 32'b1111); check("ss_cnt4", 32'(count), 32'd2);
        req = 11'(1 << 1);  step(); check("ss_op5", 32'(op), 32'b0000); check("ss_cnt5", 32'(count), 32'd2);
        req = 11'(1 << 2);  step(); check("ss_op6", 32'(op), 32'b0001); check("ss_cnt6", 32'(count), 32'd2);
        req_valid = 1'b0;
        step(); check("ss_tail_op", 32'(op), 32'b0010);
        step(); check("ss_empty", 32'(count), 32'd0);

        // Multi-hot and zero requests.
        op_ready = 1'b0;
        req = 11'h408; req_valid = 1'b1; step();
        req = 11'h000; step();
        req_valid = 1'b0;
`ifdef ILLEGAL_CHECK_EN
        check("bad_count",   32'(count),   32'd0);
        check("bad_illegal", 32'(illegal), 32'd1);
        step();
        check("bad_sticky",  32'(illegal), 32'd1);
        req = 11'(1 << 3); req_valid = 1'b1; step();
        req = 11'(1 << 4); step();
        req = 11'(1 << 5); step();
        req_valid = 1'b0;
`else
        check("mh_op",      32'(op),      32'b1111);
        check("mh_count",   32'(count),   32'd2);
        check("mh_illegal", 32'(illegal), 32'd0);
        req = 11'(1 << 3); req_valid = 1'b1; step();
        req_valid = 1'b0;
`endif
        check("pre_rst_count", 32'(count), 32'd3);

        // Asynchronous reset mid-stream.
        rst = 1'b1;
        #1;
        check("arst_vld",     32'(op_valid),  32'd0);
        check("arst_count",   32'(count),     32'd0);
        check("arst_illegal", 32'(illegal),   32'd0);
        check("arst_ready",   32'(req_ready), 32'd1);
        step();
        rst = 1'b0;
        req = 11'(1 << 8); req_valid = 1'b1;
        check("nobypass_vld", 32'(op_valid), 32'd0);
        step();
        req_valid = 1'b0;
        check("post_rst_op",    32'(op),       32'b1100);
        check("post_rst_vld",   32'(op_valid), 32'd1);
        check("post_rst_count", 32'(count),    32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
